// File: rtl/me_search_scheduler.sv
// Full-search motion-estimation scheduler: raster-scans all N*N window offsets, keeps min SAD and its MV.
// Build option ME_EARLY_TERM_EN: finish as soon as best_sad drops below EARLY_THR.
`timescale 1ns/1ps
module me_search_scheduler #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int SAD_W      = 16,
    parameter int EARLY_THR  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [SAD_W-1:0]        sad,
    input  logic                    sad_valid,
    output logic                    me_start,
    output logic [5:0]              win_x,
    output logic [5:0]              win_y,
    output logic signed [6:0]       mv_x,
    output logic signed [6:0]       mv_y,
    output logic [SAD_W-1:0]        best_sad,
    output logic                    busy,
    output logic                    done
);
    localparam int              N      = SEARCH_DIM - MACRO_DIM + 1;
    localparam logic [5:0]      LAST   = 6'(N - 1);
    localparam logic [6:0]      CENTER = 7'((N - 1) / 2);
    localparam logic [SAD_W-1:0] THR   = SAD_W'(EARLY_THR);
`ifdef ME_EARLY_TERM_EN
    localparam logic EARLY_EN = 1'b1;
`else
    localparam logic EARLY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;
    state_t state;
    logic   stop;

    // best_sad is already updated by the WAIT edge, so the early check sees the latest candidate
    always_comb begin
        stop = ((win_x == LAST) && (win_y == LAST)) || (EARLY_EN && (best_sad < THR));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            me_start <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            win_x    <= '0;
            win_y    <= '0;
            mv_x     <= '0;
            mv_y     <= '0;
            best_sad <= '1;
        end else begin
            me_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ISSUE;
                        me_start <= 1'b1;
                        busy     <= 1'b1;
                        win_x    <= '0;
                        win_y    <= '0;
                        mv_x     <= '0;
                        mv_y     <= '0;
                        best_sad <= '1;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (sad_valid) begin
                        state <= NEXT;
                        // strict compare: on a tie the earlier raster candidate is kept
                        if (sad < best_sad) begin
                            best_sad <= sad;
                            mv_x     <= {1'b0, win_x} - CENTER;
                            mv_y     <= {1'b0, win_y} - CENTER;
                        end
                    end
                end
                NEXT: begin
                    if (stop) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= ISSUE;
                        me_start <= 1'b1;
                        if (win_x == LAST) begin
                            win_x <= '0;
                            win_y <= win_y + 6'd1;
                        end else begin
                            win_x <= win_x + 6'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_me_search_scheduler.sv
// Randomized bench for me_search_scheduler: a raster/min-SAD reference model checked every cycle,
// plus literal expectations for the canonical search patterns.
`timescale 1ns/1ps
module tb_me_search_scheduler;
    localparam int N   = 33;
    localparam int THR = 64;
`ifdef ME_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n, start, sad_valid;
    logic [15:0]        sad;
    logic               me_start, busy, done;
    logic [5:0]         win_x, win_y;
    logic signed [6:0]  mv_x, mv_y;
    logic [15:0]        best_sad;

    int nvec  = 0;
    int nfail = 0;
    int mode  = 0;
    bit glitch = 1'b0;

    me_search_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sad(sad), .sad_valid(sad_valid),
        .me_start(me_start), .win_x(win_x), .win_y(win_y), .mv_x(mv_x), .mv_y(mv_y),
        .best_sad(best_sad), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pat(input int md, input int x, input int y);
        case (md)
            0:       return 16'd100;
            1:       return (x == 20 && y == 5) ? 16'd20 : 16'd500;
            2:       return ((x == 3 && y == 0) || (x == 7 && y == 9)) ? 16'd30 : 16'd900;
            3:       return 16'($urandom_range(0, 65535));
            4:       return 16'($urandom_range(0, 40));
            default: return (x == 1 && y == 0) ? 16'd10 : 16'd900;
        endcase
    endfunction

    // Reference model: which candidate is in flight, when the next launch/done is due, running minimum.
    int          cyc = 0;
    int          m_idx = 0;
    int          launch_at = -1;
    int          done_at = -1;
    int          m_mvx = 0;
    int          m_mvy = 0;
    bit          m_act = 1'b0;
    bit          m_wait = 1'b0;
    logic [15:0] m_best = 16'hFFFF;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_act = 0; m_wait = 0; m_idx = 0; launch_at = -1; done_at = -1;
            m_best = 16'hFFFF; m_mvx = 0; m_mvy = 0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1; m_idx = 0; m_best = 16'hFFFF; m_mvx = 0; m_mvy = 0;
                launch_at = cyc + 1;
            end
        end else if (cyc == done_at) begin
            m_act = 0;
        end else begin
            if (m_wait && sad_valid) begin
                if (sad < m_best) begin
                    m_best = sad;
                    m_mvx  = (m_idx % N) - (N - 1) / 2;
                    m_mvy  = (m_idx / N) - (N - 1) / 2;
                end
                m_wait = 0;
                if (m_idx == N * N - 1 || (EARLY && int'(m_best) < THR)) done_at = cyc + 2;
                else begin
                    m_idx++;
                    launch_at = cyc + 2;
                end
            end
            if (cyc == launch_at) m_wait = 1;
        end
        cyc++;
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("busy", int'(busy), int'(m_act));
        chk("me_start", int'(me_start), int'(cyc == launch_at));
        chk("done", int'(done), int'(cyc == done_at));
        chk("best_sad", int'(best_sad), int'(m_best));
        chk("mv_x", int'(mv_x), m_mvx);
        chk("mv_y", int'(mv_y), m_mvy);
        if (cyc == launch_at || m_wait) begin
            chk("win_x", int'(win_x), m_idx % N);
            chk("win_y", int'(win_y), m_idx / N);
        end
    end

    // ME datapath stand-in: random latency, optional stray sad_valid outside WAIT.
    initial begin
        int cx, cy, dly;
        sad_valid = 1'b0;
        sad = '0;
        forever begin
            @(negedge clk);
            if (rst_n && me_start) begin
                cx = int'(win_x);
                cy = int'(win_y);
                sad_valid = glitch && ($urandom_range(0, 1) == 1);
                sad = '0;
                dly = int'($urandom_range(0, 2));
                for (int i = 0; i < dly; i++) begin
                    @(negedge clk);
                    sad_valid = 1'b0;
                    sad = 16'($urandom_range(0, 65535));
                end
                @(negedge clk);
                sad_valid = 1'b1;
                sad = pat(mode, cx, cy);
                @(negedge clk);
                sad_valid = glitch && ($urandom_range(0, 1) == 1);
                sad = '0;
            end else begin
                sad_valid = glitch && ($urandom_range(0, 3) == 0);
                sad = '0;
            end
        end
    end

    task automatic run_search(input int md, input bit spam, output int ncand, output int fx, output int fy);
        bit seen;
        bit first;
        seen = 0; first = 1; ncand = 0; fx = -1; fy = -1;
        mode = md;
        glitch = spam;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8000 && !seen; k++) begin
            if (me_start) begin
                ncand++;
                if (first) begin
                    fx = int'(win_x);
                    fy = int'(win_y);
                    first = 0;
                end
            end
            if (done) seen = 1;
            else begin
                start = spam && ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("done_within_budget", int'(seen), 1);
    endtask

    initial begin
        int nc, fx, fy;
        bit hit;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_best_sad", int'(best_sad), 16'hFFFF);
        chk("rst_mv_x", int'(mv_x), 0);
        chk("rst_win_x", int'(win_x), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;

        run_search(0, 1'b0, nc, fx, fy);
        chk("const_ncand", nc, 1089);
        chk("const_mv_x", int'(mv_x), -16);
        chk("const_mv_y", int'(mv_y), -16);
        chk("const_best", int'(best_sad), 100);

        run_search(1, 1'b0, nc, fx, fy);
        chk("single_mv_x", int'(mv_x), 4);
        chk("single_mv_y", int'(mv_y), -11);
        chk("single_best", int'(best_sad), 20);

        run_search(2, 1'b1, nc, fx, fy);
        chk("tie_mv_x", int'(mv_x), -13);
        chk("tie_mv_y", int'(mv_y), -16);
        chk("tie_best", int'(best_sad), 30);

        run_search(3, 1'b1, nc, fx, fy);
        run_search(4, 1'b1, nc, fx, fy);

        // abandon a search while waiting on candidate (10,2)
        mode = 0;
        glitch = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            if (m_wait && m_idx == 2 * N + 10) hit = 1;
            else @(negedge clk);
        end
        chk("reached_10_2", int'(hit), 1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_best", int'(best_sad), 16'hFFFF);
        chk("midrst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run_search(5, 1'b0, nc, fx, fy);
        chk("restart_win_x", fx, 0);
        chk("restart_win_y", fy, 0);
        chk("early_ncand", nc, EARLY ? 2 : 1089);
        chk("early_mv_x", int'(mv_x), -15);
        chk("early_mv_y", int'(mv_y), -16);
        chk("early_best", int'(best_sad), 10);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
